instr_encoder_loader: RTL and testbench

- Inverse of the immediate generator: packs decoded instruction fields (opcode, registers, funct, immediate) into a 32-bit RV32I instruction word.
- Writes each packed word sequentially into instruction memory through a valid/ready write port.
- Used for boot-time program loading and for self-checking benches that build instruction streams from fields.
- Supports the same instruction classes as the decoder: load (I), OP-IMM (I), store (S), branch (B), plus register-register (R).

---
 rtl/instr_encoder_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded RV32I instruction fields into a 32-bit instruction word and
//   writes the words sequentially into instruction memory.
//
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     start                 clears address, count, full and error state
//     in_valid / in_ready   field bundle handshake
//     Opcode, rd, rs1, rs2,
//     funct3, funct7, imm   decoded instruction fields
//     mem_we / mem_ready    memory write request / acceptance
//     mem_addr, mem_wdata   byte address and encoded instruction
//     word_count, full      words written, and word_count == DEPTH
//     err, err_code         sticky error flag, latest error (01 opcode, 10 range)
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       Opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [CNT_W-1:0] word_count,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  localparam logic [1:0] ErrOpcode = 2'b01;
  localparam logic [1:0] ErrRange  = 2'b10;

  typedef enum logic [1:0] {StIdle, StEnc, StWr} state_e;

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic [31:0]      imm_q, imm_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [31:0]      enc_word;
  logic             enc_err;
  logic [1:0]       enc_code;
  logic             imm12_ok;
  logic             imm13_ok;
  logic [CNT_W-1:0] count_inc;

  // Encoder on the registered fields; only consumed in StEnc.
  always_comb begin
    // Upper bits must be a pure sign extension of the encodable field.
    imm12_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    imm13_ok = ((&imm_q[31:12]) | ~(|imm_q[31:12])) & ~imm_q[0];
    enc_word = 32'h0;
    enc_err  = 1'b0;
    enc_code = 2'b00;
    case (opcode_q)
      OpcOp: begin
        enc_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
      end
      OpcLoad, OpcOpImm: begin
        enc_word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
        enc_err  = ~imm12_ok;
        enc_code = ErrRange;
      end
      OpcStore: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
        enc_err  = ~imm12_ok;
        enc_code = ErrRange;
      end
      OpcBranch: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q, imm_q[4:1], imm_q[11],
                    opcode_q};
        enc_err  = ~imm13_ok;
        enc_code = ErrRange;
      end
      default: begin
        enc_err  = 1'b1;
        enc_code = ErrOpcode;
      end
    endcase
  end

  assign in_ready  = (state_q == StIdle) & ~full_q;
  assign count_inc = word_count_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    imm_d        = imm_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    full_d       = full_q;
    err_d        = err_q;
    err_code_d   = err_code_q;

    if (start) begin
      // Discards any in-flight word; in_valid is ignored this cycle.
      state_d      = StIdle;
      mem_we_d     = 1'b0;
      mem_addr_d   = BASE_ADDR;
      word_count_d = '0;
      full_d       = 1'b0;
      err_d        = 1'b0;
      err_code_d   = 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            opcode_d = Opcode;
            rd_d     = rd;
            rs1_d    = rs1;
            rs2_d    = rs2;
            funct3_d = funct3;
            funct7_d = funct7;
            imm_d    = imm;
            state_d  = StEnc;
          end
        end
        StEnc: begin
          if (enc_err) begin
            err_d      = 1'b1;
            err_code_d = enc_code;
            state_d    = StIdle;
          end else begin
            mem_wdata_d = enc_word;
            mem_we_d    = 1'b1;
            state_d     = StWr;
          end
        end
        StWr: begin
          if (mem_ready) begin
            mem_we_d     = 1'b0;
            mem_addr_d   = mem_addr_q + 32'd4;
            word_count_d = count_inc;
            full_d       = (count_inc == CNT_W'(DEPTH));
            state_d      = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      opcode_q     <= 7'h0;
      rd_q         <= 5'h0;
      rs1_q        <= 5'h0;
      rs2_q        <= 5'h0;
      funct3_q     <= 3'h0;
      funct7_q     <= 7'h0;
      imm_q        <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= 32'h0;
      word_count_q <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      imm_q        <= imm_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
      full_q       <= full_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4). Expected memory writes are
// queued when a bundle is driven and checked when the write handshake occurs.
module tb_instr_encoder_loader;

  localparam int unsigned CNT_W = 9;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, in_ready;
  logic [6:0]       Opcode, funct7;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [31:0]      imm;
  logic             mem_we, mem_ready;
  logic [31:0]      mem_addr, mem_wdata;
  logic [CNT_W-1:0] word_count;
  logic             full, err;
  logic [1:0]       err_code;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(
    .DEPTH    (4),
    .BASE_ADDR(32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Opcode    (Opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .word_count(word_count),
    .full      (full),
    .err       (err),
    .err_code  (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write handshake monitor: a write completes at the next rising edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && start === 1'b0 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", mem_addr, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) chk("send_timeout_in_ready", {31'b0, in_ready}, 32'h1);
    Opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_we === 1'b1) && n < 30) begin
      cyc();
      n++;
    end
    if (n >= 30) chk("drain_timeout_pending", exp_q.size(), 32'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    Opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_count", 32'(word_count), 32'h0);
    chk("rst_full_err", {29'b0, full, err_code}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);

    // addi x1,x2,-5 with latency check
    exp_q.push_back('{addr: 32'h0, data: 32'hFFB1_0093});
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFB);
    chk("enc_in_ready", {31'b0, in_ready}, 32'h0);
    chk("enc_mem_we", {31'b0, mem_we}, 32'h0);
    cyc();
    chk("wr_mem_we_lat2", {31'b0, mem_we}, 32'h1);
    drain();
    chk("addi_count", 32'(word_count), 32'h1);

    // add x3,x1,x2 then sw x5,8(x2), back to back
    exp_q.push_back('{addr: 32'h4, data: 32'h0020_81B3});
    exp_q.push_back('{addr: 32'h8, data: 32'h0051_2423});
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
    send(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'h8);
    drain();
    chk("addsw_count", 32'(word_count), 32'h3);
    chk("addsw_addr", mem_addr, 32'hC);

    pulse_start();
    chk("start_count", 32'(word_count), 32'h0);
    chk("start_addr", mem_addr, 32'h0);

    // beq x1,x2,-4 with 5 stalled cycles
    mem_ready = 1'b0;
    exp_q.push_back('{addr: 32'h0, data: 32'hFE20_8EE3});
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stall_we", {31'b0, mem_we}, 32'h1);
      chk("stall_addr", mem_addr, 32'h0);
      chk("stall_data", mem_wdata, 32'hFE20_8EE3);
      chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
      chk("stall_count", 32'(word_count), 32'h0);
      cyc();
    end
    mem_ready = 1'b1;
    drain();
    chk("beq_count", 32'(word_count), 32'h1);

    // Error cases: nothing queued, so any write is flagged by the monitor
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    cyc();
    chk("err_imm_we", {31'b0, mem_we}, 32'h0);
    chk("err_imm_err", {31'b0, err}, 32'h1);
    chk("err_imm_code", {30'b0, err_code}, 32'h2);
    chk("err_imm_addr", mem_addr, 32'h4);
    chk("err_imm_in_ready", {31'b0, in_ready}, 32'h1);
    send(7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    cyc();
    chk("err_opc_code", {30'b0, err_code}, 32'h1);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    cyc();
    chk("err_beq_code", {30'b0, err_code}, 32'h2);
    chk("err_count", 32'(word_count), 32'h1);
    exp_q.push_back('{addr: 32'h4, data: 32'hFFB1_0093});
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFB);
    drain();
    chk("after_err_count", 32'(word_count), 32'h2);
    chk("err_sticky", {31'b0, err}, 32'h1);

    // Fill to DEPTH
    exp_q.push_back('{addr: 32'h8, data: 32'h0020_81B3});
    exp_q.push_back('{addr: 32'hC, data: 32'h0020_81B3});
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
    drain();
    chk("full_flag", {31'b0, full}, 32'h1);
    chk("full_in_ready", {31'b0, in_ready}, 32'h0);
    chk("full_count", 32'(word_count), 32'h4);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    in_valid = 1'b0;
    chk("full_ignore_count", 32'(word_count), 32'h4);
    chk("full_ignore_we", {31'b0, mem_we}, 32'h0);
    chk("full_addr", mem_addr, 32'h10);
    pulse_start();
    chk("restart_count", 32'(word_count), 32'h0);
    chk("restart_addr", mem_addr, 32'h0);
    chk("restart_full", {31'b0, full}, 32'h0);
    chk("restart_err", {29'b0, err, err_code}, 32'h0);
    chk("restart_in_ready", {31'b0, in_ready}, 32'h1);

    // start while in WR, memory stalled
    mem_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h1);
    cyc();
    chk("pre_start_we", {31'b0, mem_we}, 32'h1);
    pulse_start();
    chk("start_wr_we", {31'b0, mem_we}, 32'h0);
    chk("start_wr_count", 32'(word_count), 32'h0);
    mem_ready = 1'b1;
    cyc(); cyc();
    chk("start_wr_idle_we", {31'b0, mem_we}, 32'h0);
    chk("start_wr_idle_count", 32'(word_count), 32'h0);

    // start coincident with mem_ready in WR
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h1);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ready_count", 32'(word_count), 32'h0);
    chk("start_ready_addr", mem_addr, 32'h0);
    chk("start_ready_we", {31'b0, mem_we}, 32'h0);

    // reset during ENC, with err and mem_wdata non-zero beforehand
    send(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    cyc();
    send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h1);
    reset = 1'b1;
    cyc();
    chk("rst_enc_we", {31'b0, mem_we}, 32'h0);
    chk("rst_enc_addr", mem_addr, 32'h0);
    chk("rst_enc_wdata", mem_wdata, 32'h0);
    chk("rst_enc_count", 32'(word_count), 32'h0);
    chk("rst_enc_err", {28'b0, full, err, err_code}, 32'h0);
    reset = 1'b0;
    cyc();
    chk("rst_enc_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_enc_idle_we", {31'b0, mem_we}, 32'h0);
    chk("pending_writes", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
